// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake/apple design: the 2-bit game status
// encoding used by the controller, apple generator and snake datapath, the
// default playfield size, and the inner obstacle wall geometry.
// Optional feature macro: OBSTACLE_HIT_EN (consumers decide whether to use
// obstacle_at()).
// -----------------------------------------------------------------------------
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_DIE     = 2'd2,
        ST_RESTART = 2'd3
    } status_e;

    localparam int GRID_W_DEF = 40;
    localparam int GRID_H_DEF = 30;

    // Vertical obstacle walls: x == OBS_VX0 or x == OBS_VX1, OBS_VY_LO <= y < OBS_VY_HI
    localparam int OBS_VX0    = 4;
    localparam int OBS_VX1    = 35;
    localparam int OBS_VY_LO  = 10;
    localparam int OBS_VY_HI  = 20;
    // Horizontal obstacle walls: y == OBS_HYn, OBS_HXn_LO <= x < OBS_HXn_HI
    localparam int OBS_HY0    = 5;
    localparam int OBS_HX0_LO = 15;
    localparam int OBS_HX0_HI = 30;
    localparam int OBS_HY1    = 24;
    localparam int OBS_HX1_LO = 10;
    localparam int OBS_HX1_HI = 30;

    // True when cell (x, y) lies on one of the inner obstacle walls.
    function automatic logic obstacle_at(input logic [31:0] x, input logic [31:0] y);
        logic vert;
        logic horz;
        vert = ((x == 32'(OBS_VX0)) || (x == 32'(OBS_VX1))) &&
               (y >= 32'(OBS_VY_LO)) && (y < 32'(OBS_VY_HI));
        horz = ((y == 32'(OBS_HY0)) && (x >= 32'(OBS_HX0_LO)) && (x < 32'(OBS_HX0_HI))) ||
               ((y == 32'(OBS_HY1)) && (x >= 32'(OBS_HX1_LO)) && (x < 32'(OBS_HX1_HI)));
        return vert || horz;
    endfunction

endpackage

// File: rtl/move_tick_gen.sv
// -----------------------------------------------------------------------------
// move_tick_gen
// Movement-tick scheduler. Counts enabled cycles and emits a registered
// one-cycle tick every `period` cycles. The period is sampled while cleared
// and again at every wrap, so a period change never shortens the interval
// already in progress.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   enable      count this cycle (a disabled cycle holds the counter)
//   clear       force counter to 0 and resample period (has priority)
//   period      cycles between ticks, 32-bit unsigned, must be >= 1
//   tick        registered one-cycle pulse, high the cycle after a wrap
// -----------------------------------------------------------------------------
module move_tick_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic        tick_q, tick_d;
    logic        wrap;

    always_comb begin
        wrap     = enable && (cnt_q == (period_q - 32'd1));
        cnt_d    = cnt_q;
        period_d = period_q;
        tick_d   = 1'b0;
        if (clear) begin
            cnt_d    = '0;
            period_d = period;
        end else if (enable) begin
            if (wrap) begin
                cnt_d    = '0;
                period_d = period;
                tick_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            tick_q   <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl
// Top-level game sequencer: IDLE -> PLAY -> DIE -> RESTART -> IDLE.
// Schedules movement ticks (period shrinks with speed level), counts apples
// into a saturating score, raises the speed level every SCORE_PER_LVL apples,
// and detects border/body collisions (plus inner obstacle walls when the
// OBSTACLE_HIT_EN macro is defined).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   key_start    debounced start request (level)
//   head_x/y     snake head cell
//   body_hit     head overlaps own body
//   add_cube     apple eaten, one-cycle pulse
//   fact_status  game state 0 IDLE, 1 PLAY, 2 DIE, 3 RESTART (registered)
//   move_tick    one-cycle move pulse (registered)
//   score        apples this game, saturating at 255 (registered)
//   speed_lvl    speed level 0..3 (registered)
// -----------------------------------------------------------------------------
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W        = GRID_W_DEF,
    parameter int GRID_H        = GRID_H_DEF,
    parameter int BASE_PERIOD   = 12_500_000,
    parameter int PERIOD_STEP   = 2_500_000,
    parameter int SCORE_PER_LVL = 5,
    parameter int DIE_CYCLES    = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic [5:0] head_x,
    input  logic [4:0] head_y,
    input  logic       body_hit,
    input  logic       add_cube,
    output logic [1:0] fact_status,
    output logic       move_tick,
    output logic [7:0] score,
    output logic [1:0] speed_lvl
);

    status_e     state_q, state_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lvl_q, lvl_d;
    logic [31:0] die_cnt_q, die_cnt_d;
    logic [31:0] hx, hy;
    logic        wall_hit;
    logic        obstacle_hit;
    logic        death;
    logic [31:0] period;
    logic        tick;

    // Collision decode, evaluated every cycle and qualified by PLAY.
    always_comb begin
        hx       = 32'(head_x);
        hy       = 32'(head_y);
        wall_hit = (hx == 32'd0) || (hx >= 32'(GRID_W - 1)) ||
                   (hy == 32'd0) || (hy >= 32'(GRID_H - 1));
`ifdef OBSTACLE_HIT_EN
        obstacle_hit = obstacle_at(hx, hy);
`else
        obstacle_hit = 1'b0;
`endif
        death = (state_q == ST_PLAY) && (wall_hit || obstacle_hit || body_hit);
    end

    assign period = 32'(BASE_PERIOD) - (32'(lvl_q) * 32'(PERIOD_STEP));

    // A dying cycle disables the scheduler so a coincident wrap never ticks.
    move_tick_gen u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable ((state_q == ST_PLAY) && !death),
        .clear  (state_q != ST_PLAY),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lvl_d     = lvl_q;
        die_cnt_d = die_cnt_q;
        case (state_q)
            ST_IDLE: begin
                die_cnt_d = '0;
                if (key_start) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                die_cnt_d = '0;
                // The apple still counts on the cycle the snake dies.
                if (add_cube && (score_q != 8'hFF)) begin
                    score_d = score_q + 8'd1;
                    if (((32'(score_d) % 32'(SCORE_PER_LVL)) == 32'd0) && (lvl_q != 2'd3))
                        lvl_d = lvl_q + 2'd1;
                end
                if (death) state_d = ST_DIE;
            end
            ST_DIE: begin
                if (die_cnt_q == 32'(DIE_CYCLES - 1)) begin
                    state_d   = ST_RESTART;
                    die_cnt_d = '0;
                end else begin
                    die_cnt_d = die_cnt_q + 32'd1;
                end
            end
            ST_RESTART: begin
                state_d   = ST_IDLE;
                score_d   = '0;
                lvl_d     = '0;
                die_cnt_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            score_q   <= '0;
            lvl_q     <= '0;
            die_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lvl_q     <= lvl_d;
            die_cnt_q <= die_cnt_d;
        end
    end

    assign fact_status = state_q;
    assign move_tick   = tick;
    assign score       = score_q;
    assign speed_lvl   = lvl_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_game_ctrl
// Directed-plus-random bench for snake_game_ctrl with short sim periods.
// The reference model tracks absolute cycle numbers of the next expected tick
// and of the RESTART cycle, rather than counters.
// Honours OBSTACLE_HIT_EN in its collision rule.
// -----------------------------------------------------------------------------
module tb_snake_game_ctrl;

    localparam int BASE = 20;
    localparam int STEP = 4;
    localparam int SPL  = 5;
    localparam int DIEC = 10;
    localparam int GW   = 40;
    localparam int GH   = 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_start;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic       body_hit;
    logic       add_cube;
    logic [1:0] fact_status;
    logic       move_tick;
    logic [7:0] score;
    logic [1:0] speed_lvl;

    snake_game_ctrl #(
        .GRID_W        (GW),
        .GRID_H        (GH),
        .BASE_PERIOD   (BASE),
        .PERIOD_STEP   (STEP),
        .SCORE_PER_LVL (SPL),
        .DIE_CYCLES    (DIEC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_start   (key_start),
        .head_x      (head_x),
        .head_y      (head_y),
        .body_hit    (body_hit),
        .add_cube    (add_cube),
        .fact_status (fact_status),
        .move_tick   (move_tick),
        .score       (score),
        .speed_lvl   (speed_lvl)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_state, m_score, m_lvl, m_next_tick, m_restart_at;
    logic m_tick;

    function automatic logic is_deadly(input int x, input int y, input logic b);
        logic w, o;
        w = (x == 0) || (x >= GW - 1) || (y == 0) || (y >= GH - 1);
`ifdef OBSTACLE_HIT_EN
        o = ((x == 4 || x == 35) && y >= 10 && y < 20) ||
            (y == 5 && x >= 15 && x < 30) || (y == 24 && x >= 10 && x < 30);
`else
        o = 1'b0;
`endif
        return w || o || b;
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_lvl = 0; m_tick = 1'b0;
        m_next_tick = 0; m_restart_at = 0;
    endtask

    // Applies the rules to the inputs present at this clock edge.
    task automatic model_edge();
        logic dead;
        if (!rst_n) begin
            model_reset();
        end else begin
            cyc++;
            m_tick = 1'b0;
            case (m_state)
                0: if (key_start) begin
                    m_state = 1;
                    m_next_tick = cyc + BASE;
                end
                1: begin
                    dead = is_deadly(int'(head_x), int'(head_y), body_hit);
                    if (!dead && cyc == m_next_tick) begin
                        m_tick = 1'b1;
                        m_next_tick = cyc + BASE - m_lvl * STEP;
                    end
                    if (add_cube && m_score < 255) begin
                        m_score++;
                        if (m_score % SPL == 0 && m_lvl < 3) m_lvl++;
                    end
                    if (dead) begin
                        m_state = 2;
                        m_restart_at = cyc + DIEC;
                    end
                end
                2: if (cyc == m_restart_at) m_state = 3;
                default: begin
                    m_state = 0; m_score = 0; m_lvl = 0;
                end
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        n_assert++;
        assert (fact_status === 2'(m_state)) else begin
            n_fail++;
            $error("FAIL %s fact_status cyc=%0d observed=%0d expected=%0d", tag, cyc, fact_status, m_state);
        end
        n_assert++;
        assert (move_tick === m_tick) else begin
            n_fail++;
            $error("FAIL %s move_tick cyc=%0d observed=%0b expected=%0b", tag, cyc, move_tick, m_tick);
        end
        n_assert++;
        assert (score === 8'(m_score)) else begin
            n_fail++;
            $error("FAIL %s score cyc=%0d observed=%0d expected=%0d", tag, cyc, score, m_score);
        end
        n_assert++;
        assert (speed_lvl === 2'(m_lvl)) else begin
            n_fail++;
            $error("FAIL %s speed_lvl cyc=%0d observed=%0d expected=%0d", tag, cyc, speed_lvl, m_lvl);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Head somewhere inside the border and clear of every obstacle wall.
    task automatic safe_head();
        head_x = 6'($urandom_range(34, 5));
        head_y = 5'($urandom_range(23, 6));
    endtask

    task automatic start_game(input string tag);
        key_start = 1'b1;
        step(tag);
        key_start = 1'b0;
    endtask

    task automatic kill_and_idle(input string tag);
        head_x = 6'd0;
        step(tag);
        safe_head();
        run(DIEC + 2, tag);
    endtask

    initial begin
        logic found;
        rst_n = 1'b0; key_start = 1'b0; body_hit = 1'b0; add_cube = 1'b0;
        safe_head();
        model_reset();
        #2;
        check_outputs("reset");
        run(2, "reset_hold");
        rst_n = 1'b1;

        // Idle: apples and ticks must not appear.
        for (int i = 0; i < 4; i++) begin
            add_cube = 1'($urandom_range(1, 0));
            step("idle");
        end
        add_cube = 1'b0;

        // Start; ticks every BASE cycles.
        start_game("start");
        run(45, "base_period");

        // Five apples -> level 1, then twenty more -> level 3.
        for (int i = 0; i < 25; i++) begin
            add_cube = 1'b1;
            step("apples");
            add_cube = 1'b0;
            run($urandom_range(3, 1), "apples_gap");
            if (i == 4) run(40, "level1_period");
        end
        run(30, "level3_period");

        // Right border kill, DIE for DIEC cycles with ignored inputs, RESTART, IDLE.
        head_x = 6'd39;
        step("wall_x39");
        safe_head();
        for (int i = 0; i < DIEC + 4; i++) begin
            key_start = 1'($urandom_range(1, 0));
            add_cube  = 1'($urandom_range(1, 0));
            step("die_seq");
        end
        key_start = 1'b0; add_cube = 1'b0;
        run(2, "after_restart");

        // Body hit + apple + tick wrap on the same cycle.
        start_game("start2");
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_state == 1 && m_next_tick == cyc + 1) found = 1'b1;
            else step("seek_wrap");
        end
        n_assert++;
        assert (found) else begin
            n_fail++;
            $error("FAIL seek_wrap bound observed=%0b expected=%0b", found, 1'b1);
        end
        body_hit = 1'b1; add_cube = 1'b1;
        step("coincide");
        body_hit = 1'b0; add_cube = 1'b0;
        run(DIEC + 3, "coincide_die");

        // Async reset in the middle of DIE.
        start_game("start3");
        run(5, "play3");
        head_y = 5'd0;
        step("wall_y0");
        safe_head();
        run(4, "die3");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        run(2, "reset_in_die");
        rst_n = 1'b1;
        run(3, "post_reset");

        // Obstacle cells.
        start_game("start4");
        head_x = 6'd4; head_y = 5'd9;
        run(3, "head_4_9");
        head_y = 5'd12;
        step("head_4_12");
        safe_head();
        run(3, "after_4_12");
        kill_and_idle("obstacle_end");

        // Score saturation at 255.
        start_game("start5");
        add_cube = 1'b1;
        run(262, "saturate");
        add_cube = 1'b0;
        run(3, "saturated");
        kill_and_idle("sat_end");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            key_start = ($urandom_range(7, 0) == 0);
            add_cube  = ($urandom_range(3, 0) == 0);
            body_hit  = ($urandom_range(59, 0) == 0);
            if ($urandom_range(19, 0) == 0) begin
                head_x = 6'($urandom_range(63, 0));
                head_y = 5'($urandom_range(31, 0));
            end else begin
                safe_head();
            end
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Top-level game sequencer for the snake/apple design.
- Owns the game state machine and the movement-tick scheduler, and tracks score and speed level.
- Drives `fact_status` to the apple generator and snake datapath, and consumes `add_cube` (apple eaten) plus head coordinates.
- Decides when the snake moves, when the game dies, and when everything restarts.

Parameters:
- GRID_W, 40, playfield width in cells; legal x is 1..GRID_W-2, border at 0 and GRID_W-1.
- GRID_H, 30, playfield height in cells; legal y is 1..GRID_H-2.
- BASE_PERIOD, 12_500_000, clk cycles between move ticks at speed level 0.
- PERIOD_STEP, 2_500_000, period reduction per speed level.
- SCORE_PER_LVL, 5, apples per speed-level increment.
- DIE_CYCLES, 100_000_000, clk cycles held in DIE before RESTART.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_start  in  1  synchronous, debounced start request, level
- head_x  in  6  snake head x cell
- head_y  in  5  snake head y cell
- body_hit  in  1  head overlaps own body (from snake datapath), valid during PLAY
- add_cube  in  1  apple-eaten indication from apple generator, one-cycle pulse
- fact_status  out  2  game state: 0 IDLE, 1 PLAY, 2 DIE, 3 RESTART
- move_tick  out  1  one-cycle pulse: snake advances one cell
- score  out  8  apples eaten this game, saturating at 255
- speed_lvl  out  2  current speed level 0..3

Behaviour:
- Reset (async, rst_n=0):
  - fact_status=IDLE, move_tick=0, score=0, speed_lvl=0.
  - Tick counter and die counter cleared.
  - Reset mid-game aborts immediately to IDLE with no RESTART pulse.
- IDLE:
  - move_tick held 0; counters held at 0.
  - key_start=1 → PLAY on the next clk edge. The tick counter starts from 0 on entry.
- PLAY:
  - Tick counter counts up. When it equals period-1, move_tick=1 for exactly one cycle and the counter wraps to 0.
  - period = BASE_PERIOD - speed_lvl*PERIOD_STEP, using 32-bit unsigned arithmetic.
  - First move_tick occurs `period` cycles after entering PLAY.
- Apple eaten (add_cube=1 in PLAY):
  - score increments, saturating at 255.
  - When the new score is a nonzero multiple of SCORE_PER_LVL, speed_lvl increments, saturating at 3.
  - A new period takes effect at the next counter wrap; the current interval is not shortened.
  - add_cube outside PLAY is ignored.
- Death detection, evaluated combinationally each PLAY cycle:
  - wall_hit = head_x==0 | head_x>=GRID_W-1 | head_y==0 | head_y>=GRID_H-1.
  - wall_hit | body_hit → DIE next cycle.
- Same-cycle priority:
  - If death and add_cube coincide, DIE wins and score still counts the apple.
  - If death and the tick wrap coincide, move_tick is suppressed (0).
- DIE:
  - move_tick=0; score and speed_lvl frozen.
  - Die counter runs to DIE_CYCLES-1, then → RESTART.
  - key_start is ignored in DIE.
- RESTART:
  - Lasts exactly one cycle.
  - score, speed_lvl and both counters clear. Downstream reloads the snake and the apple (24,10).
  - Next state is IDLE.
- Registering: all outputs are registered, and fact_status changes one cycle after its cause.
- Illegal state encoding: none possible, because 2 bits map to 4 legal states; the default branch goes to IDLE.

Optional Feature:
- OBSTACLE_HIT_EN defined:
  - Head collision with the inner obstacle walls also causes DIE, with the same priority as wall_hit.
  - Obstacle walls: x==4 or x==35 with 10<=y<20; y==5 with 15<=x<30; y==24 with 10<=x<30.
- Not defined: obstacles do not exist for this block; only border and body collisions kill.

Decomposition:
- Shared package `snake_pkg`:
  - status encodings ST_IDLE/ST_PLAY/ST_DIE/ST_RESTART (2-bit), shared with apple_generate and the snake datapath.
  - Grid dimensions and the obstacle rectangle constants.
- One sub-module, `move_tick_gen`:
  - Inputs: clk, rst_n, enable, clear, period[31:0]. Output: tick.
  - Holds the wrap counter and latches period on wrap.
- Parent holds the FSM, score/level logic and collision decode.

Test Plan (sim parameters BASE_PERIOD=20, PERIOD_STEP=4, DIE_CYCLES=10, SCORE_PER_LVL=5):
1. Reset, then key_start pulse → fact_status=1 one cycle later; move_tick pulses exactly every 20 cycles; no tick before cycle 20.
2. Five add_cube pulses in PLAY → score=5, speed_lvl=1; the interval after the next wrap is 16 cycles. 20 pulses → speed_lvl stays 3 (period 8).
3. head_x=39 during PLAY → fact_status=2 next cycle; move_tick stays 0; after 10 cycles fact_status=3 for one cycle, then 0 with score=0, speed_lvl=0.
4. body_hit, add_cube and the tick wrap in the same cycle → DIE, score+1, no move_tick pulse.
5. rst_n asserted low mid-DIE → outputs clear asynchronously, fact_status=0, no RESTART state.
6. With OBSTACLE_HIT_EN: head (4,12) → DIE; head (4,9) → stays PLAY. Without the macro, head (4,12) → stays PLAY.
